// File: rtl/instr_pkg.sv
// Shared definitions for the instruction decode stage: FSM encoding, class codes,
// default end-of-program byte and the byte -> field decode function.
// No ports; imported by instr_decode_stage.
package instr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CLS_ALU    = 2'd0;
   localparam logic [1:0] CLS_LOAD   = 2'd1;
   localparam logic [1:0] CLS_STORE  = 2'd2;
   localparam logic [1:0] CLS_BRANCH = 2'd3;

   localparam logic [7:0] DEF_HALT_BYTE = 8'h00;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] operand;
      logic [1:0] op_class;
   } dec_t;

   // Class is selected by the top two opcode bits: 0-3, 4-7, 8-B, C-F.
   function automatic dec_t decode(input logic [7:0] b);
      dec_t d;
      d.opcode  = b[7:4];
      d.operand = b[3:0];
      case (b[7:6])
         2'b00:   d.op_class = CLS_ALU;
         2'b01:   d.op_class = CLS_LOAD;
         2'b10:   d.op_class = CLS_STORE;
         default: d.op_class = CLS_BRANCH;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with a combinational head (show-ahead read).
// Latency: a push is visible at head/empty the cycle after; push and pop may coincide.
// Backpressure: push while full and pop while empty are ignored; the caller gates on full/empty.
// Ports: clk, rst (sync, active high), push/push_dat, pop, head, full, empty, count.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed once written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: buffers fetched bytes, splits them into opcode/operand/class and tracks
// per-program count/checksum. Latency: byte accepted in cycle N is on op_valid in N+2.
// Backpressure: op_ready low holds the output register; instr_ready drops when the FIFO fills.
// Ports: clk, rst | instr_in/instr_valid/instr_ready, prog_done | op_valid/op_ready,
//        opcode, operand, op_class | instr_count, checksum, block_done.
module instr_decode_stage
   import instr_pkg::*;
#(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] HALT_BYTE = DEF_HALT_BYTE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr_in,
   input  logic       instr_valid,
   input  logic       prog_done,
   output logic       instr_ready,
   output logic       op_valid,
   input  logic       op_ready,
   output logic [3:0] opcode,
   output logic [3:0] operand,
   output logic [1:0] op_class,
   output logic [7:0] instr_count,
   output logic [7:0] checksum,
   output logic       block_done
);

   localparam int AW = $clog2(DEPTH);

   state_t     state;
   state_t     state_nxt;
   logic       fifo_full;
   logic       fifo_empty;
   logic [AW:0] fifo_count;
   logic [7:0] fifo_head;
   logic       accept;
   logic       is_halt;
   logic       push;
   logic       load;
   logic       drained;
   dec_t       head_dec;

   assign accept   = instr_valid && instr_ready;
   assign is_halt  = (instr_in == HALT_BYTE);
   // HALT is consumed as a marker only; it never reaches the execute stage.
   assign push     = accept && !is_halt;
   assign load     = !fifo_empty && (!op_valid || op_ready);
   assign drained  = (fifo_count == '0) && !op_valid;
   assign head_dec = decode(fifo_head);

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (instr_in),
      .pop      (load),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_RUN: begin
            if (prog_done || (accept && is_halt)) state_nxt = ST_DRAIN;
            else if (accept)                      state_nxt = ST_RUN;
         end
         ST_DRAIN: if (drained) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      instr_ready = 1'b0;
      block_done  = 1'b0;
      case (state)
         ST_IDLE, ST_RUN: instr_ready = !fifo_full && !rst;
         ST_DONE:         block_done  = 1'b1;
         default:         ;
      endcase
   end

   // Program statistics. The first accept of a program restarts them, so the
   // previous program's totals stay readable while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_count <= '0;
         checksum    <= '0;
      end else if (accept) begin
         if (state == ST_IDLE) begin
            instr_count <= is_halt ? 8'd0 : 8'd1;
            checksum    <= is_halt ? 8'h00 : instr_in;
         end else if (!is_halt) begin
            if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
            checksum <= checksum ^ instr_in;
         end
      end
   end

   // Output register: refills from the FIFO head whenever it is empty or being taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_valid <= 1'b0;
         opcode   <= '0;
         operand  <= '0;
         op_class <= '0;
      end else if (load) begin
         op_valid <= 1'b1;
         opcode   <= head_dec.opcode;
         operand  <= head_dec.operand;
         op_class <= head_dec.op_class;
      end else if (op_valid && op_ready) begin
         op_valid <= 1'b0;
      end
   end

endmodule
